// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the F/D/E front end: owns the per-stage kill bits,
// drives stalls, and keeps debug counters plus a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             predict_fail,
    input  logic             jalr_D,
    input  logic             load_use,
    input  logic             dmem_busy,
    output logic             killF,
    output logic             killD,
    output logic             killE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_timeout
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic             kill_f_q, kill_f_d;
    logic             kill_d_q, kill_d_d;
    logic             kill_e_q, kill_e_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic [CNT_W-1:0] stl_cnt_q, stl_cnt_d;

    logic pf_q, jr_q, lu_q;
    logic stall_front, flush_accept;

    // Requests from stages already holding a squashed instruction are ignored.
    assign pf_q = predict_fail & ~kill_e_q;
    assign jr_q = jalr_D & ~kill_d_q;
    assign lu_q = load_use & ~kill_d_q & ~kill_e_q;

    assign stall_front  = dmem_busy | (lu_q & ~pf_q & ~jr_q);
    assign flush_accept = ~dmem_busy & (pf_q | jr_q);

    assign stallF = stall_front;
    assign stallD = stall_front;
    assign stallE = dmem_busy;

    always_comb begin
        kill_f_d = kill_f_q;
        kill_d_d = kill_d_q;
        kill_e_d = kill_e_q;
        if (dmem_busy) begin
            kill_f_d = kill_f_q;
        end else if (pf_q) begin
            kill_f_d = 1'b0;
            kill_d_d = 1'b1;
            kill_e_d = 1'b1;
        end else if (jr_q) begin
            kill_f_d = 1'b0;
            kill_d_d = 1'b1;
            kill_e_d = kill_d_q;
        end else if (lu_q) begin
            kill_e_d = 1'b1;
        end else begin
            kill_e_d = kill_d_q;
            kill_d_d = kill_f_q;
            kill_f_d = 1'b0;
        end
    end

    // The wait counter holds the number of consecutive busy cycles, entry cycle included.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            RUN: begin
                if (dmem_busy) begin
                    state_d = MEM_WAIT;
                    wait_d  = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_busy) begin
                    wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        timeout_d = timeout_q | (dmem_busy & (wait_d >= TIMEOUT_LIM));
    end

    always_comb begin
        mis_cnt_d = mis_cnt_q;
        stl_cnt_d = stl_cnt_q;
        if (flush_accept && mis_cnt_q != '1) begin
            mis_cnt_d = mis_cnt_q + 1'b1;
        end
        if (stall_front && stl_cnt_q != '1) begin
            stl_cnt_d = stl_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
            kill_f_q  <= 1'b0;
            kill_d_q  <= 1'b1;
            kill_e_q  <= 1'b1;
            mis_cnt_q <= '0;
            stl_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            kill_f_q  <= kill_f_d;
            kill_d_q  <= kill_d_d;
            kill_e_q  <= kill_e_d;
            mis_cnt_q <= mis_cnt_d;
            stl_cnt_q <= stl_cnt_d;
        end
    end

    assign killF          = kill_f_q;
    assign killD          = kill_d_q;
    assign killE          = kill_e_q;
    assign mispredict_cnt = mis_cnt_q;
    assign stall_cnt      = stl_cnt_q;
    assign mem_timeout    = timeout_q;

endmodule
